// File: rtl/pill_batch_ctrl.sv
// Bottle-filling batch controller: drives belt and valve, counts pills per bottle and bottles per batch.
// Optional fill watchdog enabled by defining FILL_TIMEOUT_EN.
module pill_batch_ctrl #(
    parameter int CNT_W   = 8,
    parameter int BATCH_W = 8,
    parameter int TIMEOUT = 1000
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Start,
    input  logic                     Stop,
    input  logic                     SensorP,
    input  logic                     SensorB,
    input  logic [CNT_W-1:0]         NumPill,
    input  logic [BATCH_W-1:0]       NumBottle,
    output logic                     Valve,
    output logic                     BeltMotor,
    output logic [CNT_W-1:0]         PillCount,
    output logic [BATCH_W-1:0]       BottleCount,
    output logic [CNT_W+BATCH_W-1:0] TotalPills,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Fault
);

    // state    | meaning
    // sIdle    | waiting for Start with a non-zero pill target
    // sLoad    | capture targets, clear batch counters
    // sMove    | belt running until a bottle is under the valve
    // sFill    | valve open, counting pill edges
    // sRelease | belt running until the filled bottle leaves
    // sDone    | batch complete, outputs held
    // sPause   | emergency stop, interrupted state saved
    // sFault   | fill watchdog expired, only Rst exits
    typedef enum logic [2:0] {
        sIdle, sLoad, sMove, sFill, sRelease, sDone, sPause, sFault
    } state_t;

    localparam int TOT_W = CNT_W + BATCH_W;

    state_t               state, stateNxt, savedState, savedNxt;
    logic [CNT_W-1:0]     pillTarget, pillTargetNxt, pillCntNxt, pillInc;
    logic [BATCH_W-1:0]   bottleTarget, bottleTargetNxt, bottleCntNxt, bottleInc;
    logic [TOT_W-1:0]     totalNxt;
    logic                 sensorPQ, pillEdge, finalEdge;

`ifdef FILL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wdCnt, wdNxt;
`endif

    assign pillEdge  = SensorP & ~sensorPQ;
    assign pillInc   = PillCount + CNT_W'(1);
    assign bottleInc = BottleCount + BATCH_W'(1);
    assign finalEdge = pillEdge && (pillInc == pillTarget);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= sIdle;
            savedState   <= sIdle;
            pillTarget   <= '0;
            bottleTarget <= '0;
            PillCount    <= '0;
            BottleCount  <= '0;
            TotalPills   <= '0;
            sensorPQ     <= 1'b0;
`ifdef FILL_TIMEOUT_EN
            wdCnt        <= '0;
`endif
        end else begin
            state        <= stateNxt;
            savedState   <= savedNxt;
            pillTarget   <= pillTargetNxt;
            bottleTarget <= bottleTargetNxt;
            PillCount    <= pillCntNxt;
            BottleCount  <= bottleCntNxt;
            TotalPills   <= totalNxt;
            sensorPQ     <= SensorP;
`ifdef FILL_TIMEOUT_EN
            wdCnt        <= wdNxt;
`endif
        end
    end

    always_comb begin
        stateNxt        = state;
        savedNxt        = savedState;
        pillTargetNxt   = pillTarget;
        bottleTargetNxt = bottleTarget;
        pillCntNxt      = PillCount;
        bottleCntNxt    = BottleCount;
        totalNxt        = TotalPills;
`ifdef FILL_TIMEOUT_EN
        wdNxt           = wdCnt;
`endif
        case (state)
            sIdle: begin
                if (Start && NumPill != '0) stateNxt = sLoad;
            end
            sLoad: begin
                if (Stop) begin
                    stateNxt = sPause;
                    savedNxt = sLoad;
                end else begin
                    pillTargetNxt   = NumPill;
                    bottleTargetNxt = NumBottle;
                    pillCntNxt      = '0;
                    bottleCntNxt    = '0;
                    totalNxt        = '0;
                    stateNxt        = sMove;
                end
            end
            sMove: begin
                if (Stop) begin
                    stateNxt = sPause;
                    savedNxt = sMove;
                end else if (SensorB) begin
                    stateNxt   = sFill;
                    pillCntNxt = '0;
`ifdef FILL_TIMEOUT_EN
                    wdNxt      = '0;
`endif
                end
            end
            sFill: begin
                // A pill edge is counted even when Stop arrives in the same cycle.
                if (pillEdge) begin
                    pillCntNxt = pillInc;
                    totalNxt   = TotalPills + TOT_W'(1);
                end
`ifdef FILL_TIMEOUT_EN
                if (pillEdge)   wdNxt = '0;
                else if (!Stop) wdNxt = wdCnt + WD_W'(1);
`endif
                if (Stop) begin
                    stateNxt = sPause;
                    savedNxt = finalEdge ? sRelease : sFill;
                end else if (finalEdge) begin
                    stateNxt = sRelease;
                end
`ifdef FILL_TIMEOUT_EN
                else if (!pillEdge && wdCnt == WD_W'(TIMEOUT - 1)) begin
                    stateNxt = sFault;
                end
`endif
            end
            sRelease: begin
                if (Stop) begin
                    stateNxt = sPause;
                    savedNxt = sRelease;
                end else if (!SensorB) begin
                    bottleCntNxt = bottleInc;
                    if (bottleTarget != '0 && bottleInc == bottleTarget) stateNxt = sDone;
                    else                                                 stateNxt = sMove;
                end
            end
            sDone: begin
                if (Start) stateNxt = sLoad;
            end
            sPause: begin
                if (Start && !Stop) stateNxt = savedState;
            end
            sFault: begin
                stateNxt = sFault;
            end
            default: stateNxt = sIdle;
        endcase
    end

    assign Valve     = (state == sFill);
    assign BeltMotor = (state == sMove) || (state == sRelease);
    assign Busy      = (state == sLoad) || (state == sMove) || (state == sFill) ||
                       (state == sRelease) || (state == sPause);
    assign Done      = (state == sDone);
`ifdef FILL_TIMEOUT_EN
    assign Fault     = (state == sFault);
`else
    assign Fault     = 1'b0;
`endif

endmodule

// File: tb/tb_pill_batch_ctrl.sv
// Self-checking bench for pill_batch_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the batch process.
module tb_pill_batch_ctrl;
    localparam int CW = 8;
    localparam int BW = 8;
    localparam int TO = 20;

    localparam int IDLE = 0, LOAD = 1, MOVE = 2, FILL = 3, REL = 4, DONE = 5, PAUSE = 6, FAULT = 7;

    logic Clk = 0, Rst = 1, Start = 0, Stop = 0, SensorP = 0, SensorB = 0;
    logic [CW-1:0] NumPill = 0;
    logic [BW-1:0] NumBottle = 0;
    logic Valve, BeltMotor, Busy, Done, Fault;
    logic [CW-1:0] PillCount;
    logic [BW-1:0] BottleCount;
    logic [CW+BW-1:0] TotalPills;

    pill_batch_ctrl #(.CNT_W(CW), .BATCH_W(BW), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Stop(Stop), .SensorP(SensorP), .SensorB(SensorB),
        .NumPill(NumPill), .NumBottle(NumBottle), .Valve(Valve), .BeltMotor(BeltMotor),
        .PillCount(PillCount), .BottleCount(BottleCount), .TotalPills(TotalPills),
        .Busy(Busy), .Done(Done), .Fault(Fault));

    always #5 Clk = ~Clk;

    int total = 0, bad = 0;
    bit chkOn = 0;

    // behavioural model of the line
    int mSt = IDLE, mSaved = IDLE, mTgtP = 0, mTgtB = 0;
    int mPill = 0, mBottle = 0, mTotal = 0, mIdleRun = 0;
    bit mPrevP = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pauseFrom(input int s);
        mSaved = s;
        mSt = PAUSE;
    endtask

    always @(posedge Clk) begin : model
        bit e;
        e = SensorP && !mPrevP;
        mPrevP = SensorP;
        if (Rst) begin
            mSt = IDLE; mSaved = IDLE; mTgtP = 0; mTgtB = 0;
            mPill = 0; mBottle = 0; mTotal = 0; mIdleRun = 0; mPrevP = 0;
        end else begin
            case (mSt)
                IDLE:  if (Start && NumPill != 0) mSt = LOAD;
                LOAD:  if (Stop) pauseFrom(LOAD);
                       else begin
                           mTgtP = NumPill; mTgtB = NumBottle;
                           mPill = 0; mBottle = 0; mTotal = 0; mSt = MOVE;
                       end
                MOVE:  if (Stop) pauseFrom(MOVE);
                       else if (SensorB) begin mSt = FILL; mPill = 0; mIdleRun = 0; end
                FILL: begin
                    bit full;
                    full = 0;
                    if (e) begin
                        mPill = (mPill + 1) % (1 << CW);
                        mTotal = (mTotal + 1) % (1 << (CW + BW));
                        mIdleRun = 0;
                        full = (mPill == mTgtP);
                    end
                    if (Stop) pauseFrom(full ? REL : FILL);
                    else if (full) mSt = REL;
                    else if (!e) begin
                        mIdleRun++;
`ifdef FILL_TIMEOUT_EN
                        if (mIdleRun == TO) mSt = FAULT;
`endif
                    end
                end
                REL:   if (Stop) pauseFrom(REL);
                       else if (!SensorB) begin
                           mBottle = (mBottle + 1) % (1 << BW);
                           mSt = (mTgtB != 0 && mBottle == mTgtB) ? DONE : MOVE;
                       end
                DONE:  if (Start) mSt = LOAD;
                PAUSE: if (Start && !Stop) mSt = mSaved;
                default: ;
            endcase
        end
    end

    always @(negedge Clk) begin
        if (chkOn) begin
            chk("Valve", Valve, mSt == FILL);
            chk("BeltMotor", BeltMotor, mSt == MOVE || mSt == REL);
            chk("PillCount", PillCount, mPill);
            chk("BottleCount", BottleCount, mBottle);
            chk("TotalPills", TotalPills, mTotal);
            chk("Busy", Busy, mSt inside {LOAD, MOVE, FILL, REL, PAUSE});
            chk("Done", Done, mSt == DONE);
            chk("Fault", Fault, mSt == FAULT);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic waitSt(input int s, input int maxCyc);
        int n;
        n = 0;
        while (mSt != s && n < maxCyc) begin tick(); n++; end
        if (mSt != s) begin
            total++; bad++;
            $display("FAIL wait_state: got %0d expected %0d", mSt, s);
        end
    endtask

    task automatic pulse();
        SensorP = 1; tick();
        SensorP = 0; tick();
    endtask

    task automatic runBottle(input int n);
        SensorB = 1;
        waitSt(FILL, 10);
        repeat (n) pulse();
        SensorB = 0;
        tick();
    endtask

    task automatic startBatch(input int np, input int nb);
        NumPill = CW'(np); NumBottle = BW'(nb);
        Start = 1; tick();
        Start = 0; tick();
    endtask

    initial begin
        tick(); tick();
        chkOn = 1;
        chk("rst_busy", Busy, 0);
        chk("rst_pill", PillCount, 0);
        chk("rst_valve", Valve, 0);
        Rst = 0;

        // two bottles of three, with the close-timing and extra-pulse checks in bottle one
        startBatch(3, 2);
        SensorB = 1;
        waitSt(FILL, 10);
        pulse(); pulse();
        SensorP = 1; tick();
        chk("final_valve", Valve, 0);
        chk("final_pill", PillCount, 3);
        SensorP = 0; tick();
        pulse();
        chk("extra_pill", PillCount, 3);
        chk("extra_total", TotalPills, 3);
        SensorB = 0; tick();
        runBottle(3);
        chk("batch_done", Done, 1);
        chk("batch_bottles", BottleCount, 2);
        chk("batch_total", TotalPills, 6);

        // pause mid-fill and resume
        startBatch(3, 1);
        SensorB = 1;
        waitSt(FILL, 10);
        pulse();
        Stop = 1; tick();
        chk("pause_valve", Valve, 0);
        chk("pause_belt", BeltMotor, 0);
        chk("pause_pill", PillCount, 1);
        Stop = 0; tick();
        Start = 1; tick();
        Start = 0;
        chk("resume_valve", Valve, 1);
        pulse(); pulse();
        SensorB = 0; tick();
        chk("resume_done", Done, 1);
        chk("resume_total", TotalPills, 3);

        // zero pill target and continuous mode
        Rst = 1; tick(); Rst = 0;
        NumPill = 0; Start = 1; tick(); tick(); Start = 0;
        chk("zero_busy", Busy, 0);
        startBatch(2, 0);
        repeat (3) runBottle(2);
        chk("cont_done", Done, 0);
        chk("cont_bottles", BottleCount, 3);
        chk("cont_busy", Busy, 1);

        // reset during fill
        Rst = 1; tick(); Rst = 0;
        startBatch(5, 1);
        SensorB = 1;
        waitSt(FILL, 10);
        pulse(); pulse();
        chk("prerst_pill", PillCount, 2);
        Rst = 1; tick(); Rst = 0;
        chk("rst_fill_pill", PillCount, 0);
        chk("rst_fill_total", TotalPills, 0);
        chk("rst_fill_valve", Valve, 0);
        SensorB = 0;

        // fill with no pills
        startBatch(5, 1);
        SensorB = 1;
        waitSt(FILL, 10);
        repeat (TO + 5) tick();
`ifdef FILL_TIMEOUT_EN
        chk("wd_fault", Fault, 1);
        chk("wd_valve", Valve, 0);
        Start = 1; tick(); Start = 0;
        chk("wd_hold", Fault, 1);
        Rst = 1; tick(); Rst = 0;
        chk("wd_clear", Fault, 0);
`else
        chk("nowd_fault", Fault, 0);
        chk("nowd_valve", Valve, 1);
`endif
        Rst = 1; SensorB = 0; tick(); Rst = 0;

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            Rst     = ($urandom_range(0, 299) == 0);
            Start   = ($urandom_range(0, 9) == 0);
            Stop    = ($urandom_range(0, 19) == 0);
            SensorP = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 5) == 0) SensorB = ~SensorB;
            if ($urandom_range(0, 30) == 0) NumPill = CW'($urandom_range(0, 4));
            if ($urandom_range(0, 30) == 0) NumBottle = BW'($urandom_range(0, 3));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
